// File: rtl/dp_regbank_if.sv
// -----------------------------------------------------------------------------
// dp_regbank_if
//   Simple req/ack register bus between the AXI3 bridge (master) and a
//   register bank (slave). The master holds req and the command fields stable
//   until it sees ack. The slave returns ack for one cycle, with rdata and err
//   valid in that cycle.
//
//   addr   master->slave  ADDR     word address (low 2 bits ignored)
//   wdata  master->slave  DATA     write data
//   wstrb  master->slave  DATA/8   byte strobes for writes
//   wr     master->slave  1        1 = write, 0 = read
//   req    master->slave  1        access request, held until ack
//   ack    slave->master  1        one-cycle completion
//   rdata  slave->master  DATA     read data
//   err    slave->master  1        unmapped address
// -----------------------------------------------------------------------------
interface dp_regbank_if #(
  parameter int ADDR = 32,
  parameter int DATA = 32
);
  logic [ADDR-1:0]   addr;
  logic [DATA-1:0]   wdata;
  logic [DATA/8-1:0] wstrb;
  logic              wr;
  logic              req;
  logic              ack;
  logic [DATA-1:0]   rdata;
  logic              err;

  modport master (
    output addr, wdata, wstrb, wr, req,
    input  ack, rdata, err
  );

  modport slave (
    input  addr, wdata, wstrb, wr, req,
    output ack, rdata, err
  );
endinterface

// File: rtl/dp_regbank.sv
// -----------------------------------------------------------------------------
// dp_regbank
//   Control/status register bank for the DisplayPort output path.
//
//   Register map (addr[5:2]):
//     0 CTRL      RW   [0] enable, [1] soft_rst (self-clearing, reads 0),
//                      [7:4] mode
//     1 STATUS    RO   [0] enable, [1] link_up, [2] irq
//     2 IRQSTAT   W1C  [NEVT-1:0] sticky, set on evt rising edge
//     3 IRQEN     RW   [NEVT-1:0]
//     4 FRAMECNT  RO   32-bit vsync rising-edge count; any write clears it
//     5 SCRATCH   RW   32-bit
//     6..15       unmapped: read 0, writes ignored, err = 1
//
//   Ports
//     clk       in   system clock
//     reset     in   synchronous reset, active-high
//     bus       slave modport of dp_regbank_if
//     vsync     in   frame sync level
//     link_up   in   DP link status level
//     evt       in   interrupt event levels (rising edge = event)
//     enable    out  CTRL[0]
//     mode      out  CTRL[7:4]
//     soft_rst  out  one-cycle pulse on a write of 1 to CTRL[1]
//     irq       out  registered |(IRQSTAT & IRQEN)
// -----------------------------------------------------------------------------
module dp_regbank #(
  parameter int ADDR = 32,
  parameter int DATA = 32,
  parameter int NEVT = 4
) (
  input  logic            clk,
  input  logic            reset,
  dp_regbank_if.slave     bus,
  input  logic            vsync,
  input  logic            link_up,
  input  logic [NEVT-1:0] evt,
  output logic            enable,
  output logic [3:0]      mode,
  output logic            soft_rst,
  output logic            irq
);

  localparam int NSTRB = DATA / 8;

  localparam logic [3:0] A_CTRL     = 4'd0;
  localparam logic [3:0] A_STATUS   = 4'd1;
  localparam logic [3:0] A_IRQSTAT  = 4'd2;
  localparam logic [3:0] A_IRQEN    = 4'd3;
  localparam logic [3:0] A_FRAMECNT = 4'd4;
  localparam logic [3:0] A_SCRATCH  = 4'd5;

  typedef enum logic {
    S_IDLE,
    S_ACK
  } state_t;

  state_t state;

  // Command captured when the access is accepted; the write is applied from
  // these copies at the end of the ACK cycle.
  logic [3:0]       addr_q;
  logic             wr_q;
  logic [DATA-1:0]  wdata_q;
  logic [NSTRB-1:0] wstrb_q;

  logic [NEVT-1:0]  irqstat;
  logic [NEVT-1:0]  irqen;
  logic [NEVT-1:0]  evt_q;
  logic             vsync_q;
  logic [31:0]      framecnt;
  logic [DATA-1:0]  scratch;

  // Only addr[5:2] is decoded; the remaining address bits are intentionally
  // ignored.
  logic addr_unused;
  assign addr_unused = ^{bus.addr[ADDR-1:6], bus.addr[1:0]};

  // ---------------------------------------------------------------------------
  // Read decode from the live bus address; captured into rdata/err on accept.
  // ---------------------------------------------------------------------------
  logic [DATA-1:0] rd_data;
  logic            rd_err;

  // NOTE: every signal assigned in this block gets a default first so no
  // path through the case leaves it unassigned (that would infer a latch).
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (bus.addr[5:2])
      A_CTRL: begin
        rd_data[0]   = enable;
        rd_data[7:4] = mode;
      end
      A_STATUS:   rd_data[2:0]      = {irq, link_up, enable};
      A_IRQSTAT:  rd_data[NEVT-1:0] = irqstat;
      A_IRQEN:    rd_data[NEVT-1:0] = irqen;
      A_FRAMECNT: rd_data           = framecnt;
      A_SCRATCH:  rd_data           = scratch;
      default:    rd_err            = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus FSM: IDLE accepts a request, ACK presents ack for exactly one cycle.
  // req still high during ACK is the same access, so ACK always returns to
  // IDLE without looking at req.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
      bus.err   <= 1'b0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.ack <= 1'b0;
          if (bus.req) begin
            state     <= S_ACK;
            bus.ack   <= 1'b1;
            bus.rdata <= bus.wr ? '0 : rd_data;
            bus.err   <= rd_err;
            addr_q    <= bus.addr[5:2];
            wr_q      <= bus.wr;
            wdata_q   <= bus.wdata;
            wstrb_q   <= bus.wstrb;
          end
        end
        S_ACK: begin
          state   <= S_IDLE;
          bus.ack <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          bus.ack <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write decode (active only in the ACK cycle of a write).
  // ---------------------------------------------------------------------------
  logic            do_wr;
  logic [DATA-1:0] bmask;
  logic [DATA-1:0] wmasked;
  logic            wr_ctrl, wr_irqstat, wr_irqen, wr_framecnt, wr_scratch;

  always_comb begin
    for (int i = 0; i < NSTRB; i++) begin
      bmask[8*i +: 8] = {8{wstrb_q[i]}};
    end
  end

  assign do_wr       = (state == S_ACK) && wr_q;
  assign wmasked     = wdata_q & bmask;
  assign wr_ctrl     = do_wr && (addr_q == A_CTRL);
  assign wr_irqstat  = do_wr && (addr_q == A_IRQSTAT);
  assign wr_irqen    = do_wr && (addr_q == A_IRQEN);
  assign wr_framecnt = do_wr && (addr_q == A_FRAMECNT) && (|wstrb_q);
  assign wr_scratch  = do_wr && (addr_q == A_SCRATCH);

  // Edge detectors: one register stage of history, cleared on reset so a
  // level already high at reset release counts as one event.
  logic [NEVT-1:0] evt_rise;
  logic [NEVT-1:0] irq_clr;
  logic            vsync_rise;

  assign evt_rise   = evt & ~evt_q;
  assign vsync_rise = vsync & ~vsync_q;
  assign irq_clr    = wr_irqstat ? wmasked[NEVT-1:0] : '0;

  // ---------------------------------------------------------------------------
  // Register state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      enable   <= 1'b0;
      mode     <= '0;
      soft_rst <= 1'b0;
      irq      <= 1'b0;
      irqstat  <= '0;
      irqen    <= '0;
      evt_q    <= '0;
      vsync_q  <= 1'b0;
      framecnt <= '0;
      scratch  <= '0;
    end else begin
      evt_q   <= evt;
      vsync_q <= vsync;

      // Control fields all live in byte 0.
      soft_rst <= wr_ctrl && wstrb_q[0] && wdata_q[1];
      if (wr_ctrl && wstrb_q[0]) begin
        enable <= wdata_q[0];
        mode   <= wdata_q[7:4];
      end

      // Set wins over a same-cycle W1C clear of the same bit.
      irqstat <= (irqstat & ~irq_clr) | evt_rise;

      if (wr_irqen) begin
        irqen <= (irqen & ~bmask[NEVT-1:0]) | wmasked[NEVT-1:0];
      end

      if (wr_scratch) begin
        scratch <= (scratch & ~bmask) | wmasked;
      end

      // Clear wins over a same-cycle vsync edge; the counter wraps naturally.
      if (wr_framecnt) begin
        framecnt <= '0;
      end else if (vsync_rise) begin
        framecnt <= framecnt + 32'd1;
      end

      irq <= |(irqstat & irqen);
    end
  end

endmodule
